// File: rtl/pwm_symbol_transmitter.sv
// Serialises a command word onto one wire as fixed-period PWM symbols:
// one START symbol, DATA_W data symbols MSB first, then one all-low STOP symbol.
module pwm_symbol_transmitter #(
    parameter int DATA_W     = 8,
    parameter int BIT_PERIOD = 25,
    parameter int T0_HIGH    = 8,
    parameter int T1_HIGH    = 16,
    parameter int START_HIGH = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = $clog2(BIT_PERIOD);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

    generate
        if (!(DATA_W >= 1 && 0 < T0_HIGH && T0_HIGH < T1_HIGH &&
              T1_HIGH < START_HIGH && START_HIGH < BIT_PERIOD)) begin : g_bad_params
            $error("pwm_symbol_transmitter: illegal DATA_W or timing parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     sym_cnt, sym_cnt_next;
    logic [BW-1:0]     bit_cnt, bit_cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              tx_out_next;
    logic              accept;
    logic              sym_end;

    // High time of a symbol; IDLE and STOP never drive the line high.
    function automatic logic [CW-1:0] high_time(input state_t s, input logic msb);
        logic [CW-1:0] h;
        case (s)
            START:   h = CW'(START_HIGH);
            DATA:    h = msb ? CW'(T1_HIGH) : CW'(T0_HIGH);
            default: h = '0;
        endcase
        return h;
    endfunction

    assign tx_ready   = en && (state == IDLE) && !reset;
    assign busy       = (state != IDLE);
    assign accept     = tx_valid && tx_ready;
    assign sym_end    = (sym_cnt == K_LAST);
    assign frame_done = en && !reset && (state == STOP) && sym_end;

    always_comb begin
        state_next   = state;
        sym_cnt_next = sym_cnt;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = START;
                    sym_cnt_next = '0;
                    bit_cnt_next = '0;
                    shift_next   = tx_data;
                end
            end
            START: begin
                if (sym_end) begin
                    state_next   = DATA;
                    sym_cnt_next = '0;
                end else begin
                    sym_cnt_next = sym_cnt + CW'(1);
                end
            end
            DATA: begin
                if (sym_end) begin
                    sym_cnt_next = '0;
                    shift_next   = shift_reg << 1;
                    if (bit_cnt == B_LAST) begin
                        state_next   = STOP;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + BW'(1);
                    end
                end else begin
                    sym_cnt_next = sym_cnt + CW'(1);
                end
            end
            STOP: begin
                if (sym_end) begin
                    state_next   = IDLE;
                    sym_cnt_next = '0;
                end else begin
                    sym_cnt_next = sym_cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is decided from the position being entered, so the
        // registered output lines up with the counter it belongs to.
        tx_out_next = (sym_cnt_next < high_time(state_next, shift_next[DATA_W-1]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sym_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_out    <= 1'b0;
        end else if (en) begin
            state     <= state_next;
            sym_cnt   <= sym_cnt_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
            tx_out    <= tx_out_next;
        end
    end

endmodule
